mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Registered N-port arbiter between requesters (icache, dcache, tensor DMA) and the single RAM port.
//  Supports fixed-priority or round-robin grant and fixed-length bursts with per-beat handshakes.
//  Holds one transaction in flight; the winner is latched at grant. Sits between the caches and the RAM model.
// PARAMETERS
//  N_PORTS    2   number of requesters, >=1; port 0 has highest fixed priority
//  ADDR_W     32  address width in bits
//  DATA_W     32  word width in bits
//  BURST_LEN  1   beats per grant, >=1; the address advances DATA_W/8 per beat
//  ARB_MODE   1   0 = fixed priority (lowest index wins), 1 = round-robin
// PORTS
//  CLK        in   1               clock, rising edge
//  RST        in   1               synchronous reset, active-high
//  req_ren    in   N_PORTS         per-port read request
//  req_wen    in   N_PORTS         per-port write request
//  req_addr   in   N_PORTS*ADDR_W  per-port base address
//  req_store  in   N_PORTS*DATA_W  per-port write data for the current beat
//  req_wait   out  N_PORTS         1 = stall; 0 for one cycle = beat done
//  req_load   out  DATA_W          read data; valid when a req_wait bit is 0
//  req_err    out  N_PORTS         one-cycle pulse with the ack when the RAM reports ERROR
//  ramstate   in   ramstate_t      RAM status (FREE/BUSY/ACCESS/ERROR)
//  ramload    in   DATA_W          RAM read data
//  ramREN     out  1               RAM read enable
//  ramWEN     out  1               RAM write enable
//  ramaddr    out  ADDR_W          RAM address
//  ramstore   out  DATA_W          RAM write data
// BEHAVIOUR
//  Reset: state IDLE, req_wait all 1, req_err 0, req_load 0, ramREN/WEN 0, ramaddr 0, rr_ptr 0, beat 0.
//  Reset mid-burst: abandon at the next edge with no ack; RAM enables drop immediately.
//  IDLE: no port requesting -> stay. Otherwise:
//   - pick a winner; ARB_MODE=1 scans upward from rr_ptr with wrap.
//   - latch id, op, base addr and beat=0; go to ACCESS.
//   - a port with both ren and wen latches a write.
//  ACCESS:
//   - ramWEN = op, ramREN = !op; ramaddr = base + beat*(DATA_W/8), wrapping mod 2^ADDR_W.
//   - ramstore = req_store[id], combinational from the winner.
//   - ramstate ACCESS or ERROR -> register ramload (0 on ERROR); go to ACK.
//   - FREE or BUSY -> hold.
//  ACK (1 cycle): enables 0, req_wait[id]=0, req_load = registered word, req_err[id]=1 if ERROR.
//   - beat == BURST_LEN-1 -> IDLE, and rr_ptr = (id+1) mod N_PORTS.
//   - else if the winner still requests: beat++, back to ACCESS.
//   - else early terminate to IDLE, rr_ptr updated.
//  Non-winning ports keep req_wait=1. Requests arriving during a burst wait; no preemption.
//  Requester rules: hold the request while req_wait=1; present the next beat's store data by the cycle after its ack.
//  Latency: request at cycle t -> ACCESS at t+1 -> ack at t+2 minimum; each extra RAM wait cycle adds 1.
//  Back-to-back grants: the ACK->IDLE->ACCESS bubble is 1 cycle.
//  BURST_LEN=1 with N_PORTS=1 is legal and degenerates to a registered pass-through.
// STRUCTURE
//  ram_pkg gains:
//   - arb_state_t {IDLE, ACCESS, ACK}
//   - ARB_FIXED=0, ARB_RR=1
//  ramstate_t stays in ram_pkg.
//  Sub-module rr_arbiter #(N_PORTS, ARB_MODE):
//   - req vector + rr_ptr -> one-hot grant + index, combinational.
//   - the pointer register lives in mem_arbiter.
// TESTING
//  1 Reset: assert RST for 2 cycles with req_ren=2'b11 -> all waits 1, ramREN/WEN 0, then a grant 1 cycle after release.
//  2 Single read, N=2, BURST_LEN=1: port1 reads 0x100, RAM ACCESS immediately -> ramaddr=0x100, ack at t+2, req_load=ramload.
//  3 Round-robin: both ports hold reads for 4 grants -> order 0,1,0,1.
//     Repeat with ARB_MODE=0 -> order 0,0,0,0 while port 0 requests.
//  4 Write burst, BURST_LEN=4, base 0x200: ramaddr 0x200,0x204,0x208,0x20C, ramWEN=1, four acks, store data per beat.
//  5 ERROR plus latency: RAM BUSY 3 cycles then ERROR -> ack at t+5, req_err=1, req_load=0.
//     A ren+wen request at once -> write issued.
//  6 Abort: RST during beat 2 of 4 -> IDLE, no further acks.
//     Port drops its request after beat 1 -> early IDLE, rr_ptr advanced.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared RAM-side types: RAM status, arbiter FSM states and arbitration modes.
package ram_pkg;

    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;

    // S_ prefix keeps these distinct from the ramstate_t literals in the same scope
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_ACK} arb_state_t;

    localparam int unsigned ARB_FIXED = 0;
    localparam int unsigned ARB_RR    = 1;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational arbiter: picks one requester, scanning upward from rr_ptr with wrap
// in round-robin mode, or from port 0 in fixed-priority mode.
module rr_arbiter
    import ram_pkg::*;
#(
    parameter int unsigned N_PORTS  = 2,
    parameter int unsigned ARB_MODE = ARB_RR,
    localparam int unsigned IDX_W   = idx_w(N_PORTS)
) (
    input  logic [N_PORTS-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [N_PORTS-1:0] grant,
    output logic [IDX_W-1:0]   grant_id
);

    always_comb begin
        logic        found;
        int unsigned start;
        found    = 1'b0;
        grant    = '0;
        grant_id = '0;
        start    = (ARB_MODE == ARB_RR) ? 32'(rr_ptr) : 0;
        for (int unsigned i = 0; i < N_PORTS; i++) begin
            for (int unsigned j = 0; j < N_PORTS; j++) begin
                if (!found && req[j] && j == (start + i) % N_PORTS) begin
                    found    = 1'b1;
                    grant[j] = 1'b1;
                    grant_id = IDX_W'(j);
                end
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Registered N-port arbiter in front of the single RAM port: one transaction in
// flight, winner latched at grant, fixed-length bursts with one ack per beat.
module mem_arbiter
    import ram_pkg::*;
#(
    parameter int unsigned N_PORTS   = 2,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned BURST_LEN = 1,
    parameter int unsigned ARB_MODE  = ARB_RR
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [N_PORTS-1:0]          req_ren,
    input  logic [N_PORTS-1:0]          req_wen,
    input  logic [N_PORTS*ADDR_W-1:0]   req_addr,
    input  logic [N_PORTS*DATA_W-1:0]   req_store,
    output logic [N_PORTS-1:0]          req_wait,
    output logic [DATA_W-1:0]           req_load,
    output logic [N_PORTS-1:0]          req_err,
    input  ramstate_t                   ramstate,
    input  logic [DATA_W-1:0]           ramload,
    output logic                        ramREN,
    output logic                        ramWEN,
    output logic [ADDR_W-1:0]           ramaddr,
    output logic [DATA_W-1:0]           ramstore
);

    localparam int unsigned IDX_W  = idx_w(N_PORTS);
    localparam int unsigned BEAT_W = idx_w(BURST_LEN);
    localparam int unsigned BYTES  = DATA_W / 8;

    arb_state_t          state, state_n;
    logic [IDX_W-1:0]    id, rr_ptr, grant_id, id_next;
    logic                op;
    logic [ADDR_W-1:0]   base, grant_addr;
    logic [BEAT_W-1:0]   beat;
    logic [DATA_W-1:0]   load_q;
    logic                err_q;
    logic [N_PORTS-1:0]  req_any, grant, id_oh;
    logic                win_req, last_beat;

    assign req_any = req_ren | req_wen;

    rr_arbiter #(
        .N_PORTS  (N_PORTS),
        .ARB_MODE (ARB_MODE)
    ) u_arb (
        .req      (req_any),
        .rr_ptr   (rr_ptr),
        .grant    (grant),
        .grant_id (grant_id)
    );

    always_comb begin
        id_oh      = '0;
        ramstore   = '0;
        grant_addr = '0;
        for (int unsigned i = 0; i < N_PORTS; i++) begin
            if (32'(id) == i) begin
                id_oh[i] = 1'b1;
                ramstore = req_store[i*DATA_W +: DATA_W];
            end
            if (grant[i])
                grant_addr = req_addr[i*ADDR_W +: ADDR_W];
        end
    end

    assign win_req   = |(id_oh & req_any);
    assign last_beat = (32'(beat) == BURST_LEN - 1);
    assign id_next   = (32'(id) == N_PORTS - 1) ? '0 : id + IDX_W'(1);
    assign ramaddr   = base + ADDR_W'(beat) * ADDR_W'(BYTES);
    assign req_load  = load_q;

    always_comb begin
        state_n  = state;
        req_wait = '1;
        req_err  = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        case (state)
            S_IDLE: begin
                if (|grant)
                    state_n = S_ACCESS;
            end
            S_ACCESS: begin
                // enables are gated by RST so an abandoned burst stops driving the RAM at once
                ramWEN = op & ~RST;
                ramREN = ~op & ~RST;
                if (ramstate == ACCESS || ramstate == ERROR)
                    state_n = S_ACK;
            end
            S_ACK: begin
                req_wait = ~id_oh;
                req_err  = err_q ? id_oh : '0;
                state_n  = (!last_beat && win_req) ? S_ACCESS : S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= S_IDLE;
            id     <= '0;
            op     <= 1'b0;
            base   <= '0;
            beat   <= '0;
            rr_ptr <= '0;
            load_q <= '0;
            err_q  <= 1'b0;
        end else begin
            state <= state_n;
            case (state)
                S_IDLE: begin
                    if (|grant) begin
                        id   <= grant_id;
                        op   <= |(grant & req_wen);
                        base <= grant_addr;
                        beat <= '0;
                    end
                end
                S_ACCESS: begin
                    if (state_n == S_ACK) begin
                        load_q <= (ramstate == ERROR) ? '0 : ramload;
                        err_q  <= (ramstate == ERROR);
                    end
                end
                S_ACK: begin
                    if (state_n == S_ACCESS)
                        beat <= beat + BEAT_W'(1);
                    else
                        rr_ptr <= id_next;
                end
                default: ;
            endcase
        end
    end

endmodule
